// File: rtl/bulk_endp_mux_pkg.sv
// Shared types and helpers for the multi-channel bulk endpoint mux.
package bulk_endp_mux_pkg;

  localparam int ENDP_MAX = 15;

  typedef enum logic [1:0] {
    IDLE,
    OUT_PKT,
    IN_PKT
  } state_e;

  // Ceiling log2 for elaboration-time width math.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/bulk_endp_mux_pkt_fifo.sv
// Byte FIFO with tentative and committed pointers on both the write and
// read side. Tentative pointers move with traffic; commit snaps the
// committed pointer forward, rollback snaps the tentative one back.
// Pointers are one bit wider than the address so full/empty are distinct.
module pkt_fifo
  import bulk_endp_mux_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int PW        = clog2(DEPTH) + 1,
  parameter bit LOOKAHEAD = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  input  logic          wr_commit_i,
  input  logic          wr_rollback_i,
  input  logic          rd_en_i,
  input  logic          rd_commit_i,
  input  logic          rd_rollback_i,
  output logic [7:0]    data_o,
  output logic [PW-1:0] cnt_o,
  output logic [PW-1:0] used_o
);

  localparam int AW = PW - 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_q, wr_d, wr_c_q, wr_c_d;
  logic [PW-1:0] rd_q, rd_d, rd_c_q, rd_c_d;
  logic [PW-1:0] cnt_q, cnt_d;

  // Pointer update: rollback beats advance; commit takes this cycle's result.
  always_comb begin
    wr_d   = wr_q;
    wr_c_d = wr_c_q;
    rd_d   = rd_q;
    rd_c_d = rd_c_q;
    if (wr_rollback_i)  wr_d = wr_c_q;
    else if (wr_en_i)   wr_d = wr_q + 1'b1;
    if (wr_commit_i)    wr_c_d = wr_d;
    if (rd_rollback_i)  rd_d = rd_c_q;
    else if (rd_en_i)   rd_d = rd_q + 1'b1;
    if (rd_commit_i)    rd_c_d = rd_d;
    cnt_d = wr_c_d - rd_c_d;
  end

  // Pointer and committed-count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q   <= '0;
      wr_c_q <= '0;
      rd_q   <= '0;
      rd_c_q <= '0;
      cnt_q  <= '0;
    end else begin
      wr_q   <= wr_d;
      wr_c_q <= wr_c_d;
      rd_q   <= rd_d;
      rd_c_q <= rd_c_d;
      cnt_q  <= cnt_d;
    end
  end

  // Byte storage; contents are meaningless outside the pointers, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !wr_rollback_i) mem[wr_q[AW-1:0]] <= wr_data_i;
  end

  // Lookahead gives the byte at the post-update read pointer so a
  // registered consumer can load the next byte in the same cycle.
  assign data_o = LOOKAHEAD ? mem[rd_d[AW-1:0]] : mem[rd_q[AW-1:0]];
  assign cnt_o  = cnt_q;
  assign used_o = wr_q - rd_c_q;

endmodule

// File: rtl/bulk_endp_mux.sv
// N_CH bulk IN/OUT endpoint pairs behind one SIE endpoint interface.
// OUT packets commit only when clean; IN packets retire only on host ACK.
// Optional BULK_ENDP_MUX_LEVEL_EN adds per-channel committed level ports.
module bulk_endp_mux
  import bulk_endp_mux_pkg::*;
#(
  parameter int N_CH              = 2,
  parameter int ENDP_BASE         = 1,
  parameter int IN_MAXPACKETSIZE  = 8,
  parameter int OUT_MAXPACKETSIZE = 8,
  parameter int FIFO_DEPTH        = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              usb_reset_i,
  input  logic [3:0]        endp_i,
  input  logic [7:0]        out_data_i,
  input  logic              out_valid_i,
  input  logic              out_ready_i,
  input  logic              out_err_i,
  output logic              out_nak_o,
  input  logic              in_req_i,
  input  logic              in_ready_i,
  input  logic              in_data_ack_i,
  output logic [7:0]        in_data_o,
  output logic              in_valid_o,
  output logic [8*N_CH-1:0] app_out_data_o,
  output logic [N_CH-1:0]   app_out_valid_o,
  input  logic [N_CH-1:0]   app_out_ready_i,
  input  logic [8*N_CH-1:0] app_in_data_i,
  input  logic [N_CH-1:0]   app_in_valid_i,
  output logic [N_CH-1:0]   app_in_ready_o
`ifdef BULK_ENDP_MUX_LEVEL_EN
  ,
  output logic [(clog2(FIFO_DEPTH)+1)*N_CH-1:0] app_out_level_o,
  output logic [(clog2(FIFO_DEPTH)+1)*N_CH-1:0] app_in_level_o
`endif
);

  localparam int PW = clog2(FIFO_DEPTH) + 1;
  localparam int CW = (N_CH > 1) ? clog2(N_CH) : 1;
  localparam int LW = (PW > 8) ? PW : 8;

  state_e        state_q, state_d;
  logic [CW-1:0] ch_q, ch_d, last_ch_q, last_ch_d, sel;
  logic          sel_ok, fifo_rst;
  logic [LW-1:0] cnt_q, cnt_d, pkt_len;
  logic          ovf_q, ovf_d, pend_q, pend_d, in_valid_q, in_valid_d;
  logic [7:0]    in_data_q, in_data_d;

  logic [N_CH-1:0]          ow_en, ow_commit, ow_rb, ir_en, ir_commit, ir_rb;
  logic [N_CH-1:0]          o_pop, i_push;
  logic [N_CH-1:0][PW-1:0]  o_cnt, o_used, i_cnt, i_used;
  logic [N_CH-1:0][7:0]     o_data, i_data;

  assign fifo_rst = rst_i | usb_reset_i;

  // Endpoint decode: only endpoints owned by this block select a channel.
  always_comb begin
    sel    = '0;
    sel_ok = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if ((ENDP_BASE + c <= ENDP_MAX) && (endp_i == 4'(ENDP_BASE + c))) begin
        sel    = CW'(c);
        sel_ok = 1'b1;
      end
    end
  end

  // SIE-side FSM: OUT packet capture, IN packet playout, ACK retirement.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    last_ch_d  = last_ch_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    pend_d     = pend_q;
    in_valid_d = in_valid_q;
    in_data_d  = in_data_q;
    ow_en      = '0;
    ow_commit  = '0;
    ow_rb      = '0;
    ir_en      = '0;
    ir_commit  = '0;
    ir_rb      = '0;
    pkt_len    = (LW'(i_cnt[sel]) > LW'(IN_MAXPACKETSIZE)) ? LW'(IN_MAXPACKETSIZE)
                                                           : LW'(i_cnt[sel]);

    if (sel_ok && in_data_ack_i && pend_q) begin
      ir_commit[last_ch_q] = 1'b1;
      pend_d               = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (sel_ok && out_valid_i) begin
          state_d = OUT_PKT;
          ch_d    = sel;
          cnt_d   = LW'(1);
          ovf_d   = (o_used[sel] == PW'(FIFO_DEPTH));
          if (o_used[sel] != PW'(FIFO_DEPTH)) ow_en[sel] = 1'b1;
        end else if (sel_ok && in_req_i) begin
          // Only the last unACKed channel differs; rewinding all is harmless.
          ir_rb     = '1;
          ch_d      = sel;
          last_ch_d = sel;
          pend_d    = 1'b1;
          if (pkt_len != '0) begin
            state_d    = IN_PKT;
            cnt_d      = pkt_len;
            in_valid_d = 1'b1;
            in_data_d  = i_data[sel];
          end
        end
      end
      OUT_PKT: begin
        if (sel_ok && out_valid_i) begin
          if ((cnt_q >= LW'(OUT_MAXPACKETSIZE)) || (o_used[ch_q] == PW'(FIFO_DEPTH)))
            ovf_d = 1'b1;
          else
            ow_en[ch_q] = 1'b1;
          if (cnt_q <= LW'(OUT_MAXPACKETSIZE)) cnt_d = cnt_q + 1'b1;
        end
        if (sel_ok && out_ready_i) begin
          if (!out_err_i && !ovf_d) ow_commit[ch_q] = 1'b1;
          else                      ow_rb[ch_q]     = 1'b1;
          state_d = IDLE;
        end
      end
      IN_PKT: begin
        if (sel_ok && in_ready_i) begin
          ir_en[ch_q] = 1'b1;
          cnt_d       = cnt_q - 1'b1;
          if (cnt_q == LW'(1)) begin
            in_valid_d = 1'b0;
            state_d    = IDLE;
          end else begin
            in_data_d = i_data[ch_q];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and IN output registers; USB bus reset aborts like a hard reset.
  always_ff @(posedge clk_i) begin
    if (fifo_rst) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      last_ch_q  <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      pend_q     <= 1'b0;
      in_valid_q <= 1'b0;
      in_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      last_ch_q  <= last_ch_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      pend_q     <= pend_d;
      in_valid_q <= in_valid_d;
      in_data_q  <= in_data_d;
    end
  end

  assign out_nak_o  = sel_ok && ((PW'(FIFO_DEPTH) - o_cnt[sel]) < PW'(OUT_MAXPACKETSIZE));
  assign in_valid_o = in_valid_q && sel_ok;
  assign in_data_o  = in_data_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign o_pop[c]                = (o_cnt[c] != '0) && app_out_ready_i[c];
    assign i_push[c]               = app_in_valid_i[c] && (i_used[c] != PW'(FIFO_DEPTH));
    assign app_out_valid_o[c]      = (o_cnt[c] != '0);
    assign app_out_data_o[8*c +: 8] = o_data[c];
    assign app_in_ready_o[c]       = (i_used[c] != PW'(FIFO_DEPTH));
`ifdef BULK_ENDP_MUX_LEVEL_EN
    assign app_out_level_o[PW*c +: PW] = o_cnt[c];
    assign app_in_level_o[PW*c +: PW]  = i_cnt[c];
`endif

    pkt_fifo #(.DEPTH(FIFO_DEPTH), .PW(PW), .LOOKAHEAD(1'b0)) u_out (
      .clk_i        (clk_i),
      .rst_i        (fifo_rst),
      .wr_en_i      (ow_en[c]),
      .wr_data_i    (out_data_i),
      .wr_commit_i  (ow_commit[c]),
      .wr_rollback_i(ow_rb[c]),
      .rd_en_i      (o_pop[c]),
      .rd_commit_i  (o_pop[c]),
      .rd_rollback_i(1'b0),
      .data_o       (o_data[c]),
      .cnt_o        (o_cnt[c]),
      .used_o       (o_used[c])
    );

    pkt_fifo #(.DEPTH(FIFO_DEPTH), .PW(PW), .LOOKAHEAD(1'b1)) u_in (
      .clk_i        (clk_i),
      .rst_i        (fifo_rst),
      .wr_en_i      (i_push[c]),
      .wr_data_i    (app_in_data_i[8*c +: 8]),
      .wr_commit_i  (i_push[c]),
      .wr_rollback_i(1'b0),
      .rd_en_i      (ir_en[c]),
      .rd_commit_i  (ir_commit[c]),
      .rd_rollback_i(ir_rb[c]),
      .data_o       (i_data[c]),
      .cnt_o        (i_cnt[c]),
      .used_o       (i_used[c])
    );
  end

endmodule

// File: tb/tb_bulk_endp_mux.sv
// Scoreboard bench for bulk_endp_mux with default parameters.
module tb_bulk_endp_mux;

  logic        clk_i = 1'b0;
  logic        rst_i, usb_reset_i;
  logic [3:0]  endp_i;
  logic [7:0]  out_data_i;
  logic        out_valid_i, out_ready_i, out_err_i, out_nak_o;
  logic        in_req_i, in_ready_i, in_data_ack_i;
  logic [7:0]  in_data_o;
  logic        in_valid_o;
  logic [15:0] app_out_data_o;
  logic [1:0]  app_out_valid_o, app_out_ready_i;
  logic [15:0] app_in_data_i;
  logic [1:0]  app_in_valid_i, app_in_ready_o;
`ifdef BULK_ENDP_MUX_LEVEL_EN
  logic [9:0]  app_out_level_o, app_in_level_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] oq0[$], oq1[$], iq0[$], iq1[$];

  always #5 clk_i = ~clk_i;

  bulk_endp_mux dut (
    .clk_i(clk_i), .rst_i(rst_i), .usb_reset_i(usb_reset_i), .endp_i(endp_i),
    .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_ready_i(out_ready_i),
    .out_err_i(out_err_i), .out_nak_o(out_nak_o), .in_req_i(in_req_i),
    .in_ready_i(in_ready_i), .in_data_ack_i(in_data_ack_i), .in_data_o(in_data_o),
    .in_valid_o(in_valid_o), .app_out_data_o(app_out_data_o),
    .app_out_valid_o(app_out_valid_o), .app_out_ready_i(app_out_ready_i),
    .app_in_data_i(app_in_data_i), .app_in_valid_i(app_in_valid_i),
    .app_in_ready_o(app_in_ready_o)
`ifdef BULK_ENDP_MUX_LEVEL_EN
    , .app_out_level_o(app_out_level_o), .app_in_level_o(app_in_level_o)
`endif
  );

  task automatic clk1();
    @(posedge clk_i);
    #1;
  endtask

  // OUT packet from the SIE; clean packets on owned endpoints go to the scoreboard.
  task automatic send_out(input logic [3:0] ep, input int n, input logic [7:0] base, input logic err);
    endp_i = ep;
    for (int i = 0; i < n; i++) begin
      out_data_i  = base + 8'(i);
      out_valid_i = 1'b1;
      clk1();
    end
    out_valid_i = 1'b0;
    out_ready_i = 1'b1;
    out_err_i   = err;
    clk1();
    out_ready_i = 1'b0;
    out_err_i   = 1'b0;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        if (ep == 4'd1) oq0.push_back(base + 8'(i));
        else if (ep == 4'd2) oq1.push_back(base + 8'(i));
      end
    end
  endtask

  // App drains n bytes from an OUT channel, comparing against the scoreboard.
  task automatic drain_out(input int ch, input int n);
    int got;
    logic [7:0] exp;
    got = 0;
    app_out_ready_i[ch] = 1'b1;
    for (int g = 0; g < 4 * n + 4 && got < n; g++) begin
      #1;
      if (app_out_valid_o[ch]) begin
        if (ch == 0) exp = oq0.pop_front();
        else         exp = oq1.pop_front();
        checks++;
        if (app_out_data_o[8*ch +: 8] !== exp) begin
          errors++;
          $display("FAIL app_out_data ch%0d got %02h exp %02h", ch, app_out_data_o[8*ch +: 8], exp);
        end
        got++;
      end
      clk1();
    end
    app_out_ready_i[ch] = 1'b0;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL app_out_count ch%0d got %0d exp %0d", ch, got, n);
    end
  endtask

  // App pushes bytes into an IN channel; the model accepts while it has room.
  task automatic push_in(input int ch, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      app_in_data_i[8*ch +: 8] = base + 8'(i);
      app_in_valid_i[ch] = 1'b1;
      if (ch == 0) begin
        if (iq0.size() < 16) iq0.push_back(base + 8'(i));
      end else begin
        if (iq1.size() < 16) iq1.push_back(base + 8'(i));
      end
      clk1();
    end
    app_in_valid_i[ch] = 1'b0;
  endtask

  task automatic do_ack(input int ch, input int len);
    endp_i = 4'(ch + 1);
    in_data_ack_i = 1'b1;
    clk1();
    in_data_ack_i = 1'b0;
    for (int k = 0; k < len; k++) begin
      if (ch == 0) void'(iq0.pop_front());
      else         void'(iq1.pop_front());
    end
  endtask

  // IN token: expect min(queued, 8) bytes from the head of the model, then end.
  task automatic in_txn(input int ch, input bit ack);
    int len;
    logic [7:0] exp;
    len = (ch == 0) ? iq0.size() : iq1.size();
    if (len > 8) len = 8;
    endp_i   = 4'(ch + 1);
    in_req_i = 1'b1;
    clk1();
    in_req_i = 1'b0;
    #1;
    for (int k = 0; k < len; k++) begin
      exp = (ch == 0) ? iq0[k] : iq1[k];
      checks++;
      if (in_valid_o !== 1'b1 || in_data_o !== exp) begin
        errors++;
        $display("FAIL in_byte ch%0d k%0d got v%0b %02h exp %02h", ch, k, in_valid_o, in_data_o, exp);
      end
      in_ready_i = 1'b1;
      clk1();
      in_ready_i = 1'b0;
      #1;
    end
    checks++;
    if (in_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL in_end ch%0d got %0b exp 0", ch, in_valid_o);
    end
    if (ack) do_ack(ch, len);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; usb_reset_i = 1'b0; endp_i = 4'd1; out_data_i = '0;
    out_valid_i = 0; out_ready_i = 0; out_err_i = 0; in_req_i = 0;
    in_ready_i = 0; in_data_ack_i = 0; app_out_ready_i = '0;
    app_in_data_i = '0; app_in_valid_i = '0;
    clk1(); clk1();
    rst_i = 1'b0;
    #1;
    checks += 5;
    if (in_valid_o !== 1'b0)        begin errors++; $display("FAIL rst_in_valid got %0b exp 0", in_valid_o); end
    if (in_data_o !== 8'h00)        begin errors++; $display("FAIL rst_in_data got %02h exp 00", in_data_o); end
    if (app_out_valid_o !== 2'b00)  begin errors++; $display("FAIL rst_app_out_valid got %b exp 00", app_out_valid_o); end
    if (app_in_ready_o !== 2'b11)   begin errors++; $display("FAIL rst_app_in_ready got %b exp 11", app_in_ready_o); end
    if (out_nak_o !== 1'b0)         begin errors++; $display("FAIL rst_nak got %0b exp 0", out_nak_o); end
  endtask

  task automatic test_out_clean();
    send_out(4'd2, 8, 8'h10, 1'b0);
    #1;
    checks++;
    if (app_out_valid_o !== 2'b10) begin errors++; $display("FAIL out_clean_valid got %b exp 10", app_out_valid_o); end
    drain_out(1, 8);
    #1;
    checks++;
    if (app_out_valid_o !== 2'b00) begin errors++; $display("FAIL out_clean_empty got %b exp 00", app_out_valid_o); end
  endtask

  task automatic test_out_err();
    send_out(4'd1, 5, 8'h20, 1'b1);
    clk1();
    checks++;
    if (app_out_valid_o[0] !== 1'b0) begin errors++; $display("FAIL out_err_valid got %0b exp 0", app_out_valid_o[0]); end
    send_out(4'd1, 3, 8'h30, 1'b0);
    drain_out(0, 3);
    #1;
    checks++;
    if (app_out_valid_o[0] !== 1'b0) begin errors++; $display("FAIL out_err_exact got %0b exp 0", app_out_valid_o[0]); end
  endtask

  task automatic test_in_retx();
    push_in(0, 10, 8'h40);
    in_txn(0, 1'b0);
    in_txn(0, 1'b1);
    in_txn(0, 1'b1);
  endtask

  task automatic test_zlp_invalid();
    in_txn(1, 1'b1);
    clk1();
    checks++;
    if (in_valid_o !== 1'b0) begin errors++; $display("FAIL zlp_hold got %0b exp 0", in_valid_o); end
    endp_i = 4'd9;
    #1;
    checks++;
    if (out_nak_o !== 1'b0) begin errors++; $display("FAIL bad_endp_nak got %0b exp 0", out_nak_o); end
    send_out(4'd9, 4, 8'hA0, 1'b0);
    endp_i = 4'd9; in_req_i = 1'b1; clk1(); in_req_i = 1'b0;
    #1;
    checks += 2;
    if (app_out_valid_o !== 2'b00) begin errors++; $display("FAIL bad_endp_out got %b exp 00", app_out_valid_o); end
    if (in_valid_o !== 1'b0)       begin errors++; $display("FAIL bad_endp_in got %0b exp 0", in_valid_o); end
  endtask

  task automatic test_in_full();
    push_in(1, 18, 8'h60);
    #1;
    checks++;
    if (app_in_ready_o[1] !== 1'b0) begin errors++; $display("FAIL in_full_ready got %0b exp 0", app_in_ready_o[1]); end
    in_txn(1, 1'b0);
    checks++;
    if (app_in_ready_o[1] !== 1'b0) begin errors++; $display("FAIL in_inflight_ready got %0b exp 0", app_in_ready_o[1]); end
    do_ack(1, 8);
    #1;
    checks++;
    if (app_in_ready_o[1] !== 1'b1) begin errors++; $display("FAIL in_acked_ready got %0b exp 1", app_in_ready_o[1]); end
  endtask

  task automatic test_nak();
    send_out(4'd1, 8, 8'h50, 1'b0);
    #1;
    checks++;
    if (out_nak_o !== 1'b0) begin errors++; $display("FAIL nak_8 got %0b exp 0", out_nak_o); end
    send_out(4'd1, 4, 8'h58, 1'b0);
    #1;
    checks++;
    if (out_nak_o !== 1'b1) begin errors++; $display("FAIL nak_12 got %0b exp 1", out_nak_o); end
    drain_out(0, 4);
    endp_i = 4'd1;
    #1;
    checks++;
    if (out_nak_o !== 1'b0) begin errors++; $display("FAIL nak_after_pop got %0b exp 0", out_nak_o); end
  endtask

  task automatic test_usb_reset();
    send_out(4'd2, 3, 8'h80, 1'b0);
    push_in(0, 5, 8'h70);
    endp_i = 4'd1; in_req_i = 1'b1; clk1(); in_req_i = 1'b0;
    in_ready_i = 1'b1; clk1(); in_ready_i = 1'b0;
    usb_reset_i = 1'b1; clk1(); usb_reset_i = 1'b0;
    oq0.delete(); oq1.delete(); iq0.delete(); iq1.delete();
    #1;
    checks += 3;
    if (app_out_valid_o !== 2'b00) begin errors++; $display("FAIL usbrst_out_valid got %b exp 00", app_out_valid_o); end
    if (in_valid_o !== 1'b0)       begin errors++; $display("FAIL usbrst_in_valid got %0b exp 0", in_valid_o); end
    if (app_in_ready_o !== 2'b11)  begin errors++; $display("FAIL usbrst_in_ready got %b exp 11", app_in_ready_o); end
    in_txn(0, 1'b1);
    in_txn(1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_out_clean();
    test_out_err();
    test_in_retx();
    test_zlp_invalid();
    test_in_full();
    test_nak();
    test_usb_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
